// File: rtl/uart_gpio_writer_if.sv
// UART-to-GPIO write port bundle: serial line in, GPIO write strobe/data and status out.
// The master side drives the serial line; the slave side is the receiver.
interface uart_gpio_writer_if;
    logic       rx;
    logic       we;
    logic [7:0] wdata;
    logic       busy;
    logic       frame_err;

    modport master (
        output rx,
        input  we,
        input  wdata,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  rx,
        output we,
        output wdata,
        output busy,
        output frame_err
    );
endinterface

// File: rtl/uart_gpio_writer.sv
// 8N1 UART receiver that turns each valid byte into a one-cycle GPIO write strobe plus data.
// Framing errors are sticky and park the receiver until the line returns high.
module uart_gpio_writer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input logic                clk,
    input logic                rst,
    uart_gpio_writer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            ferr_q, ferr_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= bus.rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        ferr_d    = ferr_q;
        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == FullLast) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                if (cnt_q == FullLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        wdata_d = shreg_q;
                        we_d    = 1'b1;
                        ferr_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StBreak: begin
                // Hold off until the line is released so a break cannot retrigger a frame.
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign bus.we        = we_q;
    assign bus.wdata     = wdata_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_gpio_writer.sv
// Directed bench for uart_gpio_writer: drives UART frames on rx and checks strobe, data and status.
module tb_uart_gpio_writer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   we_cnt = 0;
    int   we_cyc = 0;
    int   fall_cyc = 0;
    logic we_prev = 1'b0;
    logic we_double = 1'b0;
    logic [7:0] cap [0:31];
    int   n_assert = 0;
    int   n_fail = 0;
    int   base;
    int   lat;

    uart_gpio_writer_if bus ();

    uart_gpio_writer #(.CLKS_PER_BIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (we_cnt < 32) cap[we_cnt] <= bus.wdata;
            we_cnt <= we_cnt + 1;
            we_cyc <= cyc;
            if (we_prev) we_double <= 1'b1;
        end
        we_prev <= (bus.we === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bitp);
        fall_cyc = cyc;
        bus.rx = 1'b0;
        #(bitp);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bitp);
        end
        bus.rx = stop;
        #(bitp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #7;
            bus.rx = ~bus.rx;
        end
        #1;
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_wdata", 32'(bus.wdata), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        bus.rx = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(5);

        // Single frame 0xA5 at nominal rate
        base = we_cnt;
        send_frame(8'hA5, 1'b1, 160);
        idle(20);
        check("a5_count", 32'(we_cnt - base), 32'd1);
        check("a5_wdata", 32'(bus.wdata), 32'hA5);
        lat = we_cyc - fall_cyc;
        check("a5_latency", 32'((lat >= 154 && lat <= 156) ? 155 : lat), 32'd155);
        check("a5_ferr", 32'(bus.frame_err), 32'd0);
        check("a5_busy", 32'(bus.busy), 32'd0);

        // Back-to-back frames with no idle gap
        base = we_cnt;
        send_frame(8'h00, 1'b1, 160);
        send_frame(8'hFF, 1'b1, 160);
        send_frame(8'h3C, 1'b1, 160);
        idle(20);
        check("b2b_count", 32'(we_cnt - base), 32'd3);
        check("b2b_byte0", 32'(cap[base]), 32'h00);
        check("b2b_byte1", 32'(cap[base+1]), 32'hFF);
        check("b2b_byte2", 32'(cap[base+2]), 32'h3C);
        check("b2b_wdata", 32'(bus.wdata), 32'h3C);
        check("b2b_single_cycle_we", 32'(we_double), 32'd0);

        // Start-bit glitch of 4 cycles
        base = we_cnt;
        bus.rx = 1'b0;
        #40;
        check("glitch_busy_hi", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        idle(20);
        check("glitch_busy_lo", 32'(bus.busy), 32'd0);
        check("glitch_count", 32'(we_cnt - base), 32'd0);
        check("glitch_ferr", 32'(bus.frame_err), 32'd0);

        // Framing error: 0x81 with stop bit 0, line held low 20 more bit times
        base = we_cnt;
        send_frame(8'h81, 1'b0, 160);
        #(5 * 160);
        check("ferr_set", 32'(bus.frame_err), 32'd1);
        check("ferr_busy_held", 32'(bus.busy), 32'd1);
        check("ferr_count", 32'(we_cnt - base), 32'd0);
        check("ferr_wdata_kept", 32'(bus.wdata), 32'h3C);
        #(15 * 160);
        bus.rx = 1'b1;
        idle(5);
        check("ferr_busy_release", 32'(bus.busy), 32'd0);
        check("ferr_sticky", 32'(bus.frame_err), 32'd1);
        base = we_cnt;
        send_frame(8'h42, 1'b1, 160);
        idle(20);
        check("ferr_next_count", 32'(we_cnt - base), 32'd1);
        check("ferr_next_wdata", 32'(bus.wdata), 32'h42);
        check("ferr_cleared", 32'(bus.frame_err), 32'd0);

        // Reset after four data bits of 0x5A
        base = we_cnt;
        bus.rx = 1'b0;
        #160;
        for (int i = 0; i < 4; i++) begin
            bus.rx = (8'h5A >> i) & 8'h01;
            #160;
        end
        #4;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_wdata", 32'(bus.wdata), 32'h00);
        check("mid_rst_we", 32'(bus.we), 32'd0);
        bus.rx = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(5);
        send_frame(8'h99, 1'b1, 160);
        idle(20);
        check("mid_rst_count", 32'(we_cnt - base), 32'd1);
        check("mid_rst_next_wdata", 32'(bus.wdata), 32'h99);
        check("mid_rst_ferr", 32'(bus.frame_err), 32'd0);

        // Bit-rate skew of about -3% and +3% (15.5 and 16.5 clocks per bit)
        base = we_cnt;
        send_frame(8'h55, 1'b1, 155);
        idle(20);
        send_frame(8'hAA, 1'b1, 165);
        idle(20);
        check("skew_count", 32'(we_cnt - base), 32'd2);
        check("skew_fast_byte", 32'(cap[base]), 32'h55);
        check("skew_slow_byte", 32'(cap[base+1]), 32'hAA);
        check("skew_wdata", 32'(bus.wdata), 32'hAA);
        check("skew_ferr", 32'(bus.frame_err), 32'd0);
        check("final_single_cycle_we", 32'(we_double), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
